// File: rtl/indirect_normal_accum.sv
// Accumulates 6-DoF normal equations (21 H terms, 6 g terms) over a frame; 2-cycle sample-to-accumulator latency.
// Streams 27 sums on valid/ready with no bubbles; words hold while i_ready is low; late frame starts flag o_overrun.
module indirect_normal_accum #(
  parameter int COE_BW  = 32,
  parameter int DIFF_BW = 11,
  parameter int ACC_BW  = 80,
  parameter int CNT_BW  = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_frame_start,
  input  logic                     i_frame_end,
  input  logic                     i_valid,
  input  logic [5:0][COE_BW-1:0]   i_ax,
  input  logic [5:0][COE_BW-1:0]   i_ay,
  input  logic [DIFF_BW-1:0]       i_diffs_x,
  input  logic [DIFF_BW-1:0]       i_diffs_y,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [4:0]               o_idx,
  output logic [ACC_BW-1:0]        o_data,
  output logic                     o_last,
  output logic [CNT_BW-1:0]        o_count,
  output logic                     o_overrun
);

  localparam int NH = 21;
  localparam int NG = 6;
  localparam int NW = NH + NG;
  localparam int PW = 2 * COE_BW;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic                     drain_q;
  logic [4:0]               idx_q;
  logic                     p1_vld;
  logic signed [PW-1:0]     pxx [NH];
  logic signed [PW-1:0]     pyy [NH];
  logic signed [PW-1:0]     pxd [NG];
  logic signed [PW-1:0]     pyd [NG];
  logic signed [ACC_BW-1:0] acc [NW];

  logic accept, clear, xfer, last_word;

  // Flat position of H(i,j), i<=j, in row-major upper-triangle order
  function automatic int pair_idx(input int i, input int j);
    return 6 * i - (i * (i - 1)) / 2 + (j - i);
  endfunction

  assign clear     = i_frame_start && (state_q == S_IDLE || state_q == S_ACCUM);
  assign accept    = i_valid && (state_q == S_ACCUM || (state_q == S_IDLE && i_frame_start));
  assign last_word = (idx_q == 5'(NW - 1));
  assign xfer      = (state_q == S_OUT) && i_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_frame_start) state_d = i_frame_end ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (i_frame_end) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_OUT;
      S_OUT:   if (xfer && last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      drain_q   <= 1'b0;
      idx_q     <= 5'd0;
      p1_vld    <= 1'b0;
      o_overrun <= 1'b0;
      o_count   <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= (state_q == S_DRAIN) && !drain_q;
      p1_vld    <= accept;
      o_overrun <= i_frame_start && (state_q == S_DRAIN || state_q == S_OUT);
      if (xfer) idx_q <= last_word ? 5'd0 : idx_q + 5'd1;
      if (clear) o_count <= accept ? CNT_BW'(1) : '0;
      else if (accept && o_count != '1) o_count <= o_count + CNT_BW'(1);
    end
  end

  // Product stage carries no reset: p1_vld alone qualifies its contents
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int i = 0; i < 6; i++) begin
        pxd[i] <= PW'($signed(i_ax[i])) * PW'($signed(i_diffs_x));
        pyd[i] <= PW'($signed(i_ay[i])) * PW'($signed(i_diffs_y));
        for (int j = i; j < 6; j++) begin
          pxx[pair_idx(i, j)] <= PW'($signed(i_ax[i])) * PW'($signed(i_ax[j]));
          pyy[pair_idx(i, j)] <= PW'($signed(i_ay[i])) * PW'($signed(i_ay[j]));
        end
      end
    end
  end

  // A clear drops any product still in flight from an aborted frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NW; k++) acc[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NW; k++) acc[k] <= '0;
    end else if (p1_vld) begin
      for (int k = 0; k < NH; k++)
        acc[k] <= acc[k] + ACC_BW'(pxx[k]) + ACC_BW'(pyy[k]);
      for (int k = 0; k < NG; k++)
        acc[NH+k] <= acc[NH+k] + ACC_BW'(pxd[k]) + ACC_BW'(pyd[k]);
    end
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_valid = (state_q == S_OUT);
  assign o_idx   = idx_q;
  assign o_last  = o_valid && last_word;
  assign o_data  = o_valid ? acc[idx_q] : '0;

endmodule

// File: tb/tb_indirect_normal_accum.sv
// Randomized bench for indirect_normal_accum: a frame-level sum model predicts all 27 words and the sample count.
module tb_indirect_normal_accum;
  localparam int COE_BW = 32, DIFF_BW = 11, ACC_BW = 80, CNT_BW = 20, NW = 27;

  logic clk = 1'b0;
  logic rst, fs, fe, vld, rdy;
  logic [5:0][COE_BW-1:0] ax_bus, ay_bus;
  logic [DIFF_BW-1:0] dx_bus, dy_bus;
  logic busy, ovld, olast, oovr;
  logic [4:0] oidx;
  logic [ACC_BW-1:0] odata;
  logic [CNT_BW-1:0] ocnt;

  indirect_normal_accum #(.COE_BW(COE_BW), .DIFF_BW(DIFF_BW), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_frame_end(fe), .i_valid(vld),
    .i_ax(ax_bus), .i_ay(ay_bus), .i_diffs_x(dx_bus), .i_diffs_y(dy_bus), .i_ready(rdy),
    .o_busy(busy), .o_valid(ovld), .o_idx(oidx), .o_data(odata), .o_last(olast),
    .o_count(ocnt), .o_overrun(oovr)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ax[6], ay[6], dx, dy;
  logic signed [ACC_BW-1:0] mh [6][6];
  logic signed [ACC_BW-1:0] mg [6];
  logic signed [ACC_BW-1:0] exp_words [NW];
  logic signed [ACC_BW-1:0] got [NW];
  int m_cnt = 0, exp_cnt = 0;
  bit m_open = 0;
  int frames_closed = 0, frames_done = 0;
  int rdy_mode = 0, exp_idx = 0, cyc_n = 0, first_cyc = 0, last_cyc = 0;
  bit seen_first = 0;

  task automatic chk(input string name, input logic signed [ACC_BW-1:0] act,
                     input logic signed [ACC_BW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Frame-level model: sums of Jacobian products over every counted sample
  task automatic model_step(input bit v, input bit s, input bit e);
    int k;
    bit busy_m;
    busy_m = frames_closed > frames_done;
    if (s && !busy_m) begin
      for (int i = 0; i < 6; i++) begin
        mg[i] = '0;
        for (int j = 0; j < 6; j++) mh[i][j] = '0;
      end
      m_cnt = 0;
      m_open = 1;
    end
    if (v && m_open) begin
      for (int i = 0; i < 6; i++) begin
        mg[i] += ACC_BW'(ax[i]) * ACC_BW'(dx) + ACC_BW'(ay[i]) * ACC_BW'(dy);
        for (int j = i; j < 6; j++)
          mh[i][j] += ACC_BW'(ax[i]) * ACC_BW'(ax[j]) + ACC_BW'(ay[i]) * ACC_BW'(ay[j]);
      end
      if (m_cnt < (1 << CNT_BW) - 1) m_cnt++;
    end
    if (e && m_open) begin
      m_open = 0;
      k = 0;
      for (int i = 0; i < 6; i++)
        for (int j = i; j < 6; j++) begin
          exp_words[k] = mh[i][j];
          k++;
        end
      for (int i = 0; i < 6; i++) exp_words[21+i] = mg[i];
      exp_cnt = m_cnt;
      frames_closed++;
    end
  endtask

  task automatic cyc(input bit v, input bit s, input bit e);
    vld = v; fs = s; fe = e;
    for (int i = 0; i < 6; i++) begin
      ax_bus[i] = COE_BW'(ax[i]);
      ay_bus[i] = COE_BW'(ay[i]);
    end
    dx_bus = dx[DIFF_BW-1:0];
    dy_bus = dy[DIFF_BW-1:0];
    model_step(v, s, e);
    @(posedge clk); #1;
    vld = 0; fs = 0; fe = 0;
  endtask

  task automatic rand_sample();
    for (int i = 0; i < 6; i++) begin
      ax[i] = int'($urandom);
      ay[i] = int'($urandom);
    end
    dx = int'($urandom_range(0, 2047)) - 1024;
    dy = int'($urandom_range(0, 2047)) - 1024;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 6; i++) begin
      ax[i] = i + 1;
      ay[i] = 0;
    end
    dx = 2; dy = 0;
  endtask

  task automatic rand_frame(input int nsmp, input bit restart);
    rand_sample();
    cyc(bit'($urandom_range(0, 1)), 1'b1, nsmp == 0);
    for (int k = 0; k < nsmp; k++) begin
      rand_sample();
      cyc($urandom_range(0, 3) != 0, restart && (k == nsmp / 2), k == nsmp - 1);
    end
  endtask

  task automatic wait_done(input int budget);
    int n, target;
    n = 0;
    target = frames_closed;
    while (frames_done < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (frames_done < target) chk("frame_done_timeout", frames_done, target);
    else begin
      chk("busy_after_out", busy, 0);
      chk("count", ocnt, exp_cnt);
    end
  endtask

  task automatic wait_valid_idx(input int idx, input int budget);
    int n;
    n = 0;
    while (!(ovld && oidx == idx) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(ovld && oidx == idx)) chk("wait_idx_timeout", oidx, idx);
  endtask

  task automatic ready_loop();
    bit prev_v;
    prev_v = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = prev_v ? ~rdy : 1'b1;
        default: rdy = bit'($urandom_range(0, 1));
      endcase
      prev_v = ovld;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst) begin
        exp_idx = 0;
        seen_first = 0;
        frames_done = frames_closed;
      end else if (ovld) begin
        if (frames_done >= frames_closed) chk("spurious_valid", ovld, 0);
        else begin
          if (!seen_first) begin
            seen_first = 1;
            first_cyc = cyc_n;
          end
          chk("o_idx", oidx, exp_idx);
          chk("o_data", odata, exp_words[exp_idx]);
          chk("o_last", olast, exp_idx == NW - 1);
          if (rdy) begin
            got[exp_idx] = odata;
            if (exp_idx == NW - 1) begin
              last_cyc = cyc_n;
              exp_idx = 0;
              seen_first = 0;
              frames_done++;
            end else exp_idx++;
          end
        end
      end else chk("o_last_idle", olast, 0);
    end
  endtask

  initial begin
    rst = 1; fs = 0; fe = 0; vld = 0; rdy = 1;
    ax_bus = '0; ay_bus = '0; dx_bus = '0; dy_bus = '0;
    for (int i = 0; i < 6; i++) begin ax[i] = 0; ay[i] = 0; end
    dx = 0; dy = 0;
    fork
      ready_loop();
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", ovld, 0);
    chk("rst_idx", oidx, 0);
    chk("rst_data", odata, 0);
    chk("rst_last", olast, 0);
    chk("rst_count", ocnt, 0);
    chk("rst_overrun", oovr, 0);
    rst = 0;

    // single ramp sample
    set_ramp();
    cyc(0, 1, 0);
    chk("busy_in_accum", busy, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    wait_done(200);
    chk("t1_H00", got[0], 1);
    chk("t1_H15", got[10], 12);
    chk("t1_H55", got[20], 36);
    chk("t1_g0", got[21], 2);
    chk("t1_g5", got[26], 12);
    chk("t1_count", ocnt, 1);

    // all -1 coefficients, start and end coincident with samples, ready toggling
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin ax[i] = -1; ay[i] = -1; end
    dx = -3; dy = 5;
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    wait_done(300);
    chk("t2_H00", got[0], 6);
    chk("t2_H34", got[16], 6);
    chk("t2_g0", got[21], -6);
    chk("t2_g5", got[26], -6);
    chk("t2_count", ocnt, 3);
    chk("t2_toggle_cycles", last_cyc - first_cyc + 1, 53);

    // restart after 5 of 10 samples
    rdy_mode = 2;
    rand_sample();
    cyc(0, 1, 0);
    for (int k = 0; k < 5; k++) begin rand_sample(); cyc(1, 0, 0); end
    cyc(0, 1, 0);
    for (int k = 0; k < 5; k++) begin rand_sample(); cyc(1, 0, k == 4); end
    wait_done(300);
    chk("restart_count", ocnt, 5);

    // frame_start during OUT is rejected and flagged
    rdy_mode = 0;
    rand_frame(4, 0);
    wait_valid_idx(0, 50);
    cyc(0, 1, 0);
    chk("overrun_pulse", oovr, 1);
    @(posedge clk); #1;
    chk("overrun_clear", oovr, 0);
    wait_done(200);

    // empty frame
    cyc(0, 1, 1);
    wait_done(200);
    chk("empty_H", got[13], 0);
    chk("empty_g", got[24], 0);
    chk("empty_count", ocnt, 0);

    // reset in the middle of the output burst
    rdy_mode = 1;
    rand_frame(6, 0);
    wait_valid_idx(10, 300);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_valid", ovld, 0);
    chk("midrst_idx", oidx, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", ocnt, 0);
    rst = 0;
    m_open = 0;
    set_ramp();
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    wait_done(300);
    chk("postrst_H00", got[0], 1);
    chk("postrst_H55", got[20], 36);
    chk("postrst_count", ocnt, 1);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      rdy_mode = int'($urandom_range(0, 2));
      rand_frame(int'($urandom_range(0, 10)), $urandom_range(0, 3) == 0);
      wait_done(300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
